timer_ctrl: RTL

- Control FSM on the command side of the `timer` down-counter: generates `load`, `init` and `en` for the timer and consumes the timer's count value.
- Debounced user buttons arrive as synchronous levels. The block edge-detects them, prescales the system clock into decrement enables, supports pause/resume/clear, detects expiry (count==0) and drives a timed alarm pulse.
- Sits between the button/switch input logic and the timer instance in the lab top level.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_ctrl_if.sv | 26 ++
 rtl/timer_ctrl_edge_detect.sv | 17 +
 rtl/timer_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer command-side controller: state encoding,
// default timer width and a width helper.
package timer_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_RUN     = 3'b010,
    S_PAUSE   = 3'b011,
    S_EXPIRED = 3'b100
  } state_t;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Button/timer-side signal bundle of timer_ctrl. The master drives buttons,
// start value and the timer count; the slave (controller) drives timer controls.
interface timer_ctrl_if import timer_pkg::*; #(
  parameter int N = N_DEFAULT
);
  logic         start_btn;
  logic         pause_btn;
  logic         clear_btn;
  logic [N-1:0] init_val;
  logic [N-1:0] count_in;
  logic         load;
  logic         en;
  logic [N-1:0] init_out;
  logic         alarm;
  logic [2:0]   state_out;

  modport master (
    output start_btn, pause_btn, clear_btn, init_val, count_in,
    input  load, en, init_out, alarm, state_out
  );

  modport slave (
    input  start_btn, pause_btn, clear_btn, init_val, count_in,
    output load, en, init_out, alarm, state_out
  );
endinterface

// File: rtl/timer_ctrl_edge_detect.sv
// Rising-edge detector for one synchronous button level. prev resets low, so a
// level held through reset release yields a single edge on the first cycle.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic edge_o
);
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level_i;
  end

  assign edge_o = level_i & ~prev_q;
endmodule

// File: rtl/timer_ctrl.sv
// Command-side FSM for the timer down-counter: button edges, prescaled
// decrement enables, pause/resume/clear, expiry detection and alarm pulse.
//
// state   | meaning
// IDLE    | waiting for a start edge
// LOAD    | one cycle, timer captures init_out
// RUN     | prescaler advancing, en every DIV cycles until count hits 0
// PAUSE   | prescaler frozen, no en
// EXPIRED | alarm high for ALARM_LEN cycles
module timer_ctrl import timer_pkg::*; #(
  parameter int N         = N_DEFAULT,
  parameter int DIV       = 4,
  parameter int ALARM_LEN = 8
) (
  input logic         clk,
  input logic         rst,
  timer_ctrl_if.slave bus
);
  localparam int PW = clog2(DIV);
  localparam int AW = clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [AW-1:0] ALM_START = AW'(ALARM_LEN - 1);

  logic start_e, pause_e, clear_e;

  edge_detect u_start (.clk(clk), .rst(rst), .level_i(bus.start_btn), .edge_o(start_e));
  edge_detect u_pause (.clk(clk), .rst(rst), .level_i(bus.pause_btn), .edge_o(pause_e));
  edge_detect u_clear (.clk(clk), .rst(rst), .level_i(bus.clear_btn), .edge_o(clear_e));

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] alm_q, alm_d;
  logic [N-1:0]  init_q, init_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      alm_q   <= '0;
      init_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      alm_q   <= alm_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    alm_d   = alm_q;
    init_d  = init_q;
    if (clear_e) begin
      state_d = S_IDLE;
      pre_d   = '0;
      alm_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_e) begin
            state_d = S_LOAD;
            init_d  = bus.init_val;
          end
        end
        S_LOAD: begin
          state_d = S_RUN;
          pre_d   = '0;
        end
        S_RUN: begin
          if (start_e) begin
            state_d = S_LOAD;
            init_d  = bus.init_val;
            pre_d   = '0;
          end else if (bus.count_in == '0) begin
            state_d = S_EXPIRED;
            alm_d   = ALM_START;
          end else if (pause_e) begin
            state_d = S_PAUSE;
          end else begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (start_e) begin
            state_d = S_LOAD;
            init_d  = bus.init_val;
            pre_d   = '0;
          end else if (pause_e) begin
            state_d = S_RUN;
          end
        end
        S_EXPIRED: begin
          if (start_e) begin
            state_d = S_LOAD;
            init_d  = bus.init_val;
            pre_d   = '0;
            alm_d   = '0;
          end else if (alm_q == '0) begin
            state_d = S_IDLE;
          end else begin
            alm_d = alm_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.load      = (state_q == S_LOAD);
  assign bus.en        = (state_q == S_RUN) && (pre_q == PRE_LAST) && (bus.count_in != '0);
  assign bus.alarm     = (state_q == S_EXPIRED);
  assign bus.state_out = state_q;
  assign bus.init_out  = init_q;
endmodule
